mem: RTL and testbench

- Memory stage of the 5-stage RV32I pipeline. It sits directly downstream of the execute stage's EX/MEM register.
- It consumes the registered ALU result, store data and control, and owns the data-memory request/response handshake. It performs byte/half/word store masking and load extraction with sign/zero extension.
- It stalls the pipeline while a memory access is outstanding, and drives the MEM/WB register consumed by writeback.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_ldst_align.sv | 29 ++
 rtl/mem.sv | 91 +++++++++
 tb/tb_mem.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: funct3 load/store codes, stage FSM encoding and MEM/WB record shared by the memory stage
package mem_pkg;
  localparam logic [31:0] NOP_INST = 32'h00000033;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  typedef struct packed {
    logic        vld;
    logic [4:0]  rd_waddr;
    logic        rd_wen;
    logic [31:0] rd_wdata;
    logic        trap;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] nxt_pc;
  } wb_t;
endpackage

// File: rtl/mem_ldst_align.sv
// mem_ldst_align: store lane masking/replication, load lane extraction/extension and misalignment detect
module mem_ldst_align
  import mem_pkg::*;
(
  input  logic [2:0]  opsel,
  input  logic [1:0]  addr,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_mask,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data,
  output logic        mis
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = ld_word[{addr, 3'b000} +: 8];
    h = addr[1] ? ld_word[31:16] : ld_word[15:0];
    st_mask = opsel[1:0] == F3_B[1:0] ? 4'b0001 << addr :
              opsel[1:0] == F3_H[1:0] ? 4'b0011 << addr : 4'b1111;
    st_wdata = opsel[1:0] == F3_B[1:0] ? {4{st_data[7:0]}} :
               opsel[1:0] == F3_H[1:0] ? {2{st_data[15:0]}} : st_data;
    ld_data = opsel == F3_B  ? {{24{b[7]}}, b} :
              opsel == F3_BU ? {24'b0, b} :
              opsel == F3_H  ? {{16{h[15]}}, h} :
              opsel == F3_HU ? {16'b0, h} : ld_word;
    mis = (opsel[1:0] == F3_H[1:0] & addr[0]) | (opsel == F3_W & addr != 2'b00);
  end
endmodule

// File: rtl/mem.sv
// mem: RV32I memory stage; drives the dmem handshake, stalls while an access is outstanding, feeds MEM/WB
module mem #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INST = mem_pkg::NOP_INST
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_vld,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic            i_mem_reg,
  input  logic [2:0]      i_opsel,
  input  logic [XLEN-1:0] i_res,
  input  logic [XLEN-1:0] i_rs2_rdata,
  input  logic [4:0]      i_rd_waddr,
  input  logic            i_rd_wen,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_nxt_pc,
  output logic            o_dmem_req,
  output logic            o_dmem_ren,
  output logic            o_dmem_wen,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_mask,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_ready,
  input  logic            i_dmem_valid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_stall,
  output logic            o_vld,
  output logic [4:0]      o_rd_waddr,
  output logic            o_rd_wen,
  output logic [XLEN-1:0] o_rd_wdata,
  output logic            o_trap,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_nxt_pc
);
  import mem_pkg::*;
  state_e      state_q, state_d;
  wb_t         wb_q, wb_d;
  logic        memop, mis, mis_raw, acc, done;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata, ld_data;
  mem_ldst_align u_align (
    .opsel   (i_opsel),
    .addr    (i_res[1:0]),
    .st_data (i_rs2_rdata),
    .ld_word (i_dmem_rdata),
    .st_mask (st_mask),
    .st_wdata(st_wdata),
    .ld_data (ld_data),
    .mis     (mis_raw)
  );
  // upstream is frozen by o_stall, so IDLE and REQ present the same request
  always_comb begin
    memop = i_vld & (i_mem_read | i_mem_write);
    mis = memop & mis_raw;
    o_dmem_req = ~i_rst & memop & ~mis & (state_q != RESP);
    o_dmem_ren = i_mem_read;
    o_dmem_wen = i_mem_write;
    o_dmem_addr = {i_res[XLEN-1:2], 2'b00};
    o_dmem_mask = i_mem_write ? st_mask : 4'b1111;
    o_dmem_wdata = st_wdata;
    acc = o_dmem_req & i_dmem_ready;
    done = ~memop | mis | (i_mem_write & acc) | (state_q == RESP & i_dmem_valid);
    o_stall = ~i_rst & ~done;
    state_d = state_q == RESP ? (i_dmem_valid ? IDLE : RESP) :
              acc ? (i_mem_write ? IDLE : RESP) : o_dmem_req ? REQ : IDLE;
    wb_d = '{vld: i_vld & done, rd_waddr: i_rd_waddr, rd_wen: i_vld & done & i_rd_wen & ~mis,
             rd_wdata: i_mem_reg ? ld_data : i_res, trap: mis, inst: done ? i_inst : NOP_INST,
             pc: i_pc, nxt_pc: i_nxt_pc};
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      wb_q <= '{inst: NOP_INST, default: '0};
    end else begin
      state_q <= state_d;
      wb_q <= wb_d;
    end
  end
  assign o_vld = wb_q.vld;
  assign o_rd_waddr = wb_q.rd_waddr;
  assign o_rd_wen = wb_q.rd_wen;
  assign o_rd_wdata = wb_q.rd_wdata;
  assign o_trap = wb_q.trap;
  assign o_inst = wb_q.inst;
  assign o_pc = wb_q.pc;
  assign o_nxt_pc = wb_q.nxt_pc;
endmodule

// File: tb/tb_mem.sv
// tb_mem: scoreboard bench for the memory stage with a scripted dmem responder
module tb_mem;
  import mem_pkg::*;
  logic        i_clk = 0, i_rst = 1, i_vld = 0, i_mem_read = 0, i_mem_write = 0, i_mem_reg = 0;
  logic [2:0]  i_opsel = 0;
  logic [31:0] i_res = 0, i_rs2_rdata = 0, i_inst = 0, i_pc = 0, i_nxt_pc = 0, i_dmem_rdata = 0;
  logic [4:0]  i_rd_waddr = 0;
  logic        i_rd_wen = 0, i_dmem_ready = 0, i_dmem_valid = 0;
  logic        o_dmem_req, o_dmem_ren, o_dmem_wen, o_stall, o_vld, o_rd_wen, o_trap;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_rd_wdata, o_inst, o_pc, o_nxt_pc;
  logic [3:0]  o_dmem_mask;
  logic [4:0]  o_rd_waddr;
  always #5 i_clk = ~i_clk;
  mem dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_reg(i_mem_reg), .i_opsel(i_opsel), .i_res(i_res), .i_rs2_rdata(i_rs2_rdata),
    .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen), .i_inst(i_inst), .i_pc(i_pc), .i_nxt_pc(i_nxt_pc),
    .o_dmem_req(o_dmem_req), .o_dmem_ren(o_dmem_ren), .o_dmem_wen(o_dmem_wen),
    .o_dmem_addr(o_dmem_addr), .o_dmem_mask(o_dmem_mask), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_ready(i_dmem_ready), .i_dmem_valid(i_dmem_valid), .i_dmem_rdata(i_dmem_rdata),
    .o_stall(o_stall), .o_vld(o_vld), .o_rd_waddr(o_rd_waddr), .o_rd_wen(o_rd_wen),
    .o_rd_wdata(o_rd_wdata), .o_trap(o_trap), .o_inst(o_inst), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc)
  );
  int checks = 0, errors = 0;
  logic [31:0] pc_n = 32'h1000;
  typedef struct {
    logic [31:0] wdata;
    logic        wen;
    logic        trap;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst && o_vld) begin
      if (sb.size() == 0) chk("wb_unexpected_vld", o_vld, 0);
      else begin
        e = sb.pop_front();
        chk("wb_pc", o_pc, e.pc);
        chk("wb_nxt_pc", o_nxt_pc, e.pc + 4);
        chk("wb_inst", o_inst, e.pc ^ 32'h5a5a0000);
        chk("wb_wen", o_rd_wen, e.wen);
        chk("wb_trap", o_trap, e.trap);
        chk("wb_waddr", o_rd_waddr, 5);
        if (!e.trap) chk("wb_wdata", o_rd_wdata, e.wdata);
      end
    end
  end
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] res, input logic [31:0] rs2, input logic [31:0] rdata,
                        input int rdy_dly, input int exp_stall, input logic exp_req,
                        input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_wb, input logic exp_trap);
    int stalls = 0, waits = 0, after = -1;
    logic seen = 0, fin = 0;
    @(negedge i_clk);
    pc_n += 4;
    i_vld = 1; i_mem_read = rd; i_mem_write = wr; i_mem_reg = rd; i_opsel = f3; i_res = res;
    i_rs2_rdata = rs2; i_rd_waddr = 5; i_rd_wen = ~wr; i_pc = pc_n; i_nxt_pc = pc_n + 4;
    i_inst = pc_n ^ 32'h5a5a0000; i_dmem_rdata = rdata; i_dmem_ready = 0; i_dmem_valid = 0;
    sb.push_back('{wdata: exp_wb, wen: ~wr & ~exp_trap, trap: exp_trap, pc: pc_n});
    for (int c = 0; c < 20 && !fin; c++) begin
      if (c > 0) @(negedge i_clk);
      if (after > 0) after--;
      i_dmem_valid = after == 0;
      #1;
      i_dmem_ready = o_dmem_req && waits >= rdy_dly;
      #1;
      if (o_dmem_req) begin
        if (!seen) begin
          chk({tag, "_addr"}, o_dmem_addr, {res[31:2], 2'b00});
          chk({tag, "_mask"}, o_dmem_mask, exp_mask);
          chk({tag, "_rw"}, {o_dmem_ren, o_dmem_wen}, {rd, wr});
          if (wr) chk({tag, "_wdata"}, o_dmem_wdata, exp_wdata);
        end
        seen = 1;
        waits++;
      end
      if (i_dmem_valid) after = -1;
      if (i_dmem_ready) after = 1;
      if (o_stall) stalls++;
      else fin = 1;
    end
    if (!fin) chk({tag, "_timeout"}, fin, 1);
    chk({tag, "_stalls"}, stalls, exp_stall);
    chk({tag, "_req"}, seen, exp_req);
  endtask
  task automatic idle(input int n);
    @(negedge i_clk);
    i_vld = 0; i_mem_read = 0; i_mem_write = 0; i_dmem_ready = 0; i_dmem_valid = 0;
    repeat (n) @(negedge i_clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
  initial begin
    i_vld = 1; i_mem_read = 1; i_opsel = F3_W; i_res = 32'h40;
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_vld", o_vld, 0);
    chk("rst_inst", o_inst, NOP_INST);
    chk("rst_pc", o_pc, 0);
    chk("rst_wdata", o_rd_wdata, 0);
    chk("rst_trap", o_trap, 0);
    chk("rst_wen", o_rd_wen, 0);
    chk("rst_req", o_dmem_req, 0);
    chk("rst_stall", o_stall, 0);
    i_vld = 0; i_mem_read = 0; i_rst = 0;
    run_op("alu", 0, 0, F3_B, 32'h1234, 0, 0, 0, 0, 0, 4'h0, 0, 32'h1234, 0);
    run_op("sb", 0, 1, F3_B, 32'h103, 32'hAABBCCDD, 0, 0, 0, 1, 4'b1000, 32'hDDDDDDDD, 32'h103, 0);
    run_op("lb", 1, 0, F3_B, 32'h102, 0, 32'h00800000, 2, 3, 1, 4'hf, 0, 32'hFFFFFF80, 0);
    run_op("lbu", 1, 0, F3_BU, 32'h102, 0, 32'h00800000, 2, 3, 1, 4'hf, 0, 32'h00000080, 0);
    run_op("lh_mis", 1, 0, F3_H, 32'h101, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1);
    run_op("lw", 1, 0, F3_W, 32'h104, 0, 32'hCAFEF00D, 0, 1, 1, 4'hf, 0, 32'hCAFEF00D, 0);
    run_op("sh", 0, 1, F3_H, 32'h002, 32'h1234ABCD, 0, 0, 0, 1, 4'b1100, 32'hABCDABCD, 32'h2, 0);
    run_op("lh", 1, 0, F3_H, 32'h000, 0, 32'h00008001, 1, 2, 1, 4'hf, 0, 32'hFFFF8001, 0);
    run_op("sw_mis", 0, 1, F3_W, 32'h006, 32'h11111111, 0, 0, 0, 0, 4'h0, 0, 0, 1);
    idle(2);
    i_vld = 1; i_mem_read = 1; i_mem_reg = 1; i_opsel = F3_W; i_res = 32'h300; i_rd_wen = 1;
    #1;
    i_dmem_ready = o_dmem_req;
    #1;
    chk("abort_req", o_dmem_req, 1);
    @(negedge i_clk);
    i_dmem_ready = 0;
    #1;
    chk("abort_resp_stall", o_stall, 1);
    chk("abort_resp_req", o_dmem_req, 0);
    i_rst = 1;
    @(negedge i_clk);
    i_rst = 0; i_vld = 0; i_mem_read = 0;
    #1;
    chk("abort_stall", o_stall, 0);
    chk("abort_vld", o_vld, 0);
    chk("abort_inst", o_inst, NOP_INST);
    run_op("lw_post", 1, 0, F3_W, 32'h200, 0, 32'h12345678, 0, 1, 1, 4'hf, 0, 32'h12345678, 0);
    run_op("sw", 0, 1, F3_W, 32'h000, 32'hBEEF1234, 0, 0, 0, 1, 4'hf, 32'hBEEF1234, 32'h0, 0);
    run_op("lhu", 1, 0, F3_HU, 32'h002, 0, 32'hBEEF1234, 0, 1, 1, 4'hf, 0, 32'h0000BEEF, 0);
    idle(3);
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
